// File: rtl/msi_snoop_cache_ctrl_if.sv
// Signal bundle between an MSI cache controller and its CPU port and shared bus.
// Handshake: the CPU raises cpu_valid with cpu_we/cpu_addr stable and holds them
// until it sees the registered cpu_ack pulse. It then drops or changes the request.
// Snoops are single-cycle: snp_valid qualifies snp_op/snp_addr only in the cycle it is high.
interface msi_snoop_cache_ctrl_if #(
   parameter int LINES  = 4,
   parameter int ADDR_W = 8
);
   logic              cpu_valid;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_ack;
   logic              cpu_hit;
   logic              snp_valid;
   logic [1:0]        snp_op;
   logic [ADDR_W-1:0] snp_addr;
   logic              snp_flush;
   logic [1:0]        bus_op;
   logic [ADDR_W-1:0] bus_addr;
   logic              bus_wb;
   logic [ADDR_W-1:0] wb_addr;
   logic              proto_err;
   logic [2*LINES-1:0] dbg_line_state;   // line i state at [2i+1:2i]

   // Controller side
   modport slave (
      input  cpu_valid, cpu_we, cpu_addr, snp_valid, snp_op, snp_addr,
      output cpu_ack, cpu_hit, snp_flush, bus_op, bus_addr, bus_wb, wb_addr,
             proto_err, dbg_line_state
   );

   // CPU / bus agent side
   modport master (
      output cpu_valid, cpu_we, cpu_addr, snp_valid, snp_op, snp_addr,
      input  cpu_ack, cpu_hit, snp_flush, bus_op, bus_addr, bus_wb, wb_addr,
             proto_err, dbg_line_state
   );
endinterface

// File: rtl/msi_snoop_cache_ctrl.sv
// MSI coherence controller for a direct-mapped cache of LINES lines.
// Each line keeps a state (I/S/M) and a tag. CPU requests and bus snoops are
// resolved in one cycle; every output is registered.
module msi_snoop_cache_ctrl #(
   parameter int LINES  = 4,
   parameter int ADDR_W = 8
) (
   input logic                   clock,
   input logic                   reset,
   msi_snoop_cache_ctrl_if.slave port
);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX_W;

   typedef enum logic [1:0] {
      ST_I = 2'b00,
      ST_S = 2'b01,
      ST_M = 2'b10,
      ST_X = 2'b11    // never written; decodes as not valid
   } line_st_t;

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_INV = 2'b01;
   localparam logic [1:0] OP_WR  = 2'b10;
   localparam logic [1:0] OP_NUL = 2'b11;

   line_st_t          st_q   [LINES];
   line_st_t          st_d   [LINES];
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [TAG_W-1:0]  tag_d  [LINES];

   logic              ack_q, ack_d;
   logic              hit_q, hit_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] baddr_q, baddr_d;
   logic              wb_q, wb_d;
   logic [ADDR_W-1:0] wbaddr_q, wbaddr_d;
   logic              flush_q, flush_d;
   logic              perr_q, perr_d;

   logic [IDX_W-1:0]  s_idx, c_idx;
   logic [TAG_W-1:0]  s_tag, c_tag;
   logic              snp_act, s_hit, c_hit, accept;

   assign s_idx = port.snp_addr[IDX_W-1:0];
   assign s_tag = port.snp_addr[ADDR_W-1:IDX_W];
   assign c_idx = port.cpu_addr[IDX_W-1:0];
   assign c_tag = port.cpu_addr[ADDR_W-1:IDX_W];

   // Next line states and registered outputs from this cycle's snoop and CPU request.
   always_comb begin
      st_d     = st_q;
      tag_d    = tag_q;
      ack_d    = 1'b0;
      hit_d    = 1'b0;
      op_d     = OP_NUL;
      baddr_d  = baddr_q;
      wb_d     = 1'b0;
      wbaddr_d = wbaddr_q;
      flush_d  = 1'b0;
      perr_d   = perr_q;

      snp_act = port.snp_valid && (port.snp_op != OP_NUL);
      s_hit   = (st_q[s_idx] == ST_S || st_q[s_idx] == ST_M) && (tag_q[s_idx] == s_tag);
      c_hit   = (st_q[c_idx] == ST_S || st_q[c_idx] == ST_M) && (tag_q[c_idx] == c_tag);
      // A snoop to the same line wins; the CPU retries next cycle against the new state.
      // Blocking while ack_q is high keeps one held request from being accepted twice.
      accept  = port.cpu_valid && !ack_q && !(snp_act && (s_idx == c_idx));

      if (snp_act && s_hit) begin
         case (port.snp_op)
            OP_RD: begin
               if (st_q[s_idx] == ST_M) begin
                  st_d[s_idx] = ST_S;
                  flush_d     = 1'b1;
               end
            end
            OP_WR: begin
               flush_d     = (st_q[s_idx] == ST_M);
               st_d[s_idx] = ST_I;
            end
            OP_INV: begin
               // Another cache cannot legally hold this line while we own it Modified.
               if (st_q[s_idx] == ST_M) perr_d = 1'b1;
               st_d[s_idx] = ST_I;
            end
            default: ;
         endcase
      end

      if (accept) begin
         ack_d = 1'b1;
         hit_d = c_hit;
         if (c_hit) begin
            if (port.cpu_we && st_q[c_idx] == ST_S) begin
               op_d        = OP_INV;
               baddr_d     = port.cpu_addr;
               st_d[c_idx] = ST_M;
            end
         end else begin
            op_d         = port.cpu_we ? OP_WR : OP_RD;
            baddr_d      = port.cpu_addr;
            st_d[c_idx]  = port.cpu_we ? ST_M : ST_S;
            tag_d[c_idx] = c_tag;
            // A miss on a Modified line always means a different tag: write the victim back.
            if (st_q[c_idx] == ST_M) begin
               wb_d     = 1'b1;
               wbaddr_d = {tag_q[c_idx], c_idx};
            end
         end
      end
   end

   // Line array and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < LINES; i++) begin
            st_q[i]  <= ST_I;
            tag_q[i] <= '0;
         end
         ack_q    <= 1'b0;
         hit_q    <= 1'b0;
         op_q     <= OP_NUL;
         baddr_q  <= '0;
         wb_q     <= 1'b0;
         wbaddr_q <= '0;
         flush_q  <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         st_q     <= st_d;
         tag_q    <= tag_d;
         ack_q    <= ack_d;
         hit_q    <= hit_d;
         op_q     <= op_d;
         baddr_q  <= baddr_d;
         wb_q     <= wb_d;
         wbaddr_q <= wbaddr_d;
         flush_q  <= flush_d;
         perr_q   <= perr_d;
      end
   end

   assign port.cpu_ack   = ack_q;
   assign port.cpu_hit   = hit_q;
   assign port.bus_op    = op_q;
   assign port.bus_addr  = baddr_q;
   assign port.bus_wb    = wb_q;
   assign port.wb_addr   = wbaddr_q;
   assign port.snp_flush = flush_q;
   assign port.proto_err = perr_q;

   for (genvar g = 0; g < LINES; g++) begin : g_dbg
      assign port.dbg_line_state[2*g +: 2] = st_q[g];
   end
endmodule
